// File: rtl/pc_seq_pkg.sv
// Shared encodings for the PC sequencer: pc_gen branch controls, FSM states, interrupt vector.
package pc_seq_pkg;

  localparam logic [1:0] BRA_INC = 2'd0;
  localparam logic [1:0] BRA_IRQ = 2'd1;
  localparam logic [1:0] BRA_IMM = 2'd2;
  localparam logic [1:0] BRA_REG = 2'd3;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  // Handler entry; pc_gen produces it itself when bra_ctl selects BRA_IRQ.
  localparam int IRQ_VECTOR = 0;

endpackage

// File: rtl/pc_seq_if.sv
// Decoder / pc_gen side bundle of the PC sequencer; the sequencer uses the slave modport.
interface pc_seq_if #(
  parameter int PCMSB = 8
);
  logic             stall_i;
  logic [PCMSB:0]   pc_i;
  logic             br_req_i;
  logic             br_sel_i;
  logic [PCMSB:0]   br_immed_i;
  logic [PCMSB:0]   br_reg_i;
  logic             call_i;
  logic             ret_i;
  logic             reti_i;
  logic             irq_i;
  logic             pc_en_o;
  logic [1:0]       bra_ctl_o;
  logic [PCMSB:0]   immed_o;
  logic [PCMSB:0]   reg_o;
  logic             flush_o;
  logic             irq_ack_o;
  logic             ie_o;
  logic [PCMSB:0]   epc_o;
  logic             stk_err_o;

  modport master (
    output stall_i, pc_i, br_req_i, br_sel_i, br_immed_i, br_reg_i,
           call_i, ret_i, reti_i, irq_i,
    input  pc_en_o, bra_ctl_o, immed_o, reg_o, flush_o, irq_ack_o,
           ie_o, epc_o, stk_err_o
  );

  modport slave (
    input  stall_i, pc_i, br_req_i, br_sel_i, br_immed_i, br_reg_i,
           call_i, ret_i, reti_i, irq_i,
    output pc_en_o, bra_ctl_o, immed_o, reg_o, flush_o, irq_ack_o,
           ie_o, epc_o, stk_err_o
  );
endinterface

// File: rtl/pc_stack.sv
// Circular call/return stack: pointer wraps on overflow and underflow, sticky error flag.
module pc_stack
  import pc_seq_pkg::*;
#(
  parameter int PCMSB = 8,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  logic [PCMSB:0] push_pc,
  output logic [PCMSB:0] top,
  output logic           err
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  logic [PCMSB:0] mem [DEPTH];
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  ptr_m1;
  logic [PW:0]    cnt;

  assign ptr_m1 = ptr - PTR_ONE;
  assign top    = mem[ptr_m1];

  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_pc;
  end

  // cnt saturates at both ends so the wrap cases are detectable as errors
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else if (push) begin
      ptr <= ptr + PTR_ONE;
      if (cnt == CNT_FULL) err <= 1'b1;
      else                 cnt <= cnt + CNT_ONE;
    end else if (pop) begin
      ptr <= ptr_m1;
      if (cnt == '0) err <= 1'b1;
      else           cnt <= cnt - CNT_ONE;
    end
  end
endmodule

// File: rtl/pc_seq.sv
// PC sequencer for pc_gen: branch/call/return/interrupt selection plus one-cycle annul.
// Optional hardware call stack enabled by `define PC_SEQ_CALL_STACK_EN.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int PCMSB = 8,
  parameter int DEPTH = 4
) (
  input logic     clock_i,
  input logic     reset_i,
  pc_seq_if.slave bus
);
  logic [0:0]     state;
  logic           adv;
  logic           go_flush;
  logic           do_reti;
  logic           do_ret;
  logic           do_call;
  logic           do_irq;
  logic [1:0]     bra_ctl;
  logic [PCMSB:0] reg_tgt;
  logic           ie;
  logic [PCMSB:0] epc;
  logic [PCMSB:0] stk_top;
  logic           stk_err;

  assign adv = !bus.stall_i && !reset_i;

  always_comb begin
    bra_ctl  = BRA_INC;
    reg_tgt  = bus.br_reg_i;
    go_flush = 1'b0;
    do_reti  = 1'b0;
    do_ret   = 1'b0;
    do_call  = 1'b0;
    do_irq   = 1'b0;
    // Only RUN serves requests; in FLUSH they belong to the annulled instruction
    if (state == ST_RUN) begin
      if (bus.reti_i) begin
        bra_ctl  = BRA_REG;
        reg_tgt  = epc;
        do_reti  = 1'b1;
        go_flush = 1'b1;
`ifdef PC_SEQ_CALL_STACK_EN
      end else if (bus.ret_i) begin
        bra_ctl  = BRA_REG;
        reg_tgt  = stk_top;
        do_ret   = 1'b1;
        go_flush = 1'b1;
`endif
      end else if (bus.call_i) begin
        bra_ctl  = BRA_IMM;
        do_call  = 1'b1;
        go_flush = 1'b1;
      end else if (bus.br_req_i) begin
        bra_ctl  = bus.br_sel_i ? BRA_REG : BRA_IMM;
        go_flush = 1'b1;
      end else if (bus.irq_i && ie) begin
        bra_ctl  = BRA_IRQ;
        do_irq   = 1'b1;
        go_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state <= ST_RUN;
      ie    <= 1'b1;
      epc   <= '0;
    end else if (!bus.stall_i) begin
      state <= go_flush ? ST_FLUSH : ST_RUN;
      if (do_reti) ie <= 1'b1;
      if (do_irq) begin
        epc <= bus.pc_i;
        ie  <= 1'b0;
      end
    end
  end

`ifdef PC_SEQ_CALL_STACK_EN
  pc_stack #(
    .PCMSB (PCMSB),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk     (clock_i),
    .rst     (reset_i),
    .push    (do_call && adv),
    .pop     (do_ret && adv),
    .push_pc (bus.pc_i),
    .top     (stk_top),
    .err     (stk_err)
  );
`else
  // Without the stack a return request has no effect at all
  logic unused_ret;
  logic unused_ctl;
  assign unused_ret = bus.ret_i;
  assign unused_ctl = do_ret;
  assign stk_top    = '0;
  assign stk_err    = 1'b0;
`endif

  assign bus.pc_en_o   = adv;
  assign bus.bra_ctl_o = bra_ctl;
  assign bus.immed_o   = bus.br_immed_i;
  assign bus.reg_o     = reg_tgt;
  assign bus.flush_o   = (state == ST_FLUSH) && !reset_i;
  assign bus.irq_ack_o = do_irq && adv;
  assign bus.ie_o      = ie;
  assign bus.epc_o     = epc;
  assign bus.stk_err_o = stk_err;
endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq with a behavioural pc_gen attached and a reference model of the sequencing rules.
module tb_pc_seq;
  localparam int PCMSB = 8;
  localparam int DEPTH = 4;
  localparam int W     = PCMSB + 1;
  localparam logic [PCMSB:0] ONE = 1;
  localparam logic [1:0] B_INC = 2'd0, B_IRQ = 2'd1, B_IMM = 2'd2, B_REG = 2'd3;

  logic clk = 1'b0;
  logic rst;
  logic [PCMSB:0] pc;
  int checks = 0;
  int errors = 0;

  pc_seq_if #(.PCMSB(PCMSB)) bus();

  pc_seq #(.PCMSB(PCMSB), .DEPTH(DEPTH)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // pc_gen stand-in
  assign bus.pc_i = pc;
  always @(posedge clk) begin
    if (rst) pc <= '0;
    else if (bus.pc_en_o) begin
      case (bus.bra_ctl_o)
        B_INC:   pc <= pc + ONE;
        B_IRQ:   pc <= '0;
        B_IMM:   pc <= bus.immed_o;
        default: pc <= bus.reg_o;
      endcase
    end
  end

  // Reference model state, expectations for the current cycle, and next state
  logic           m_flush, m_ie, m_err;
  logic [PCMSB:0] m_pc, m_epc;
  logic [PCMSB:0] m_stk[$];
  logic           e_pc_en, e_flush, e_ack;
  logic [1:0]     e_bra;
  logic           n_flush, n_ie, n_err;
  logic [PCMSB:0] n_pc, n_epc;

  task automatic idle_inputs();
    bus.stall_i = 0; bus.br_req_i = 0; bus.br_sel_i = 0; bus.call_i = 0;
    bus.ret_i = 0; bus.reti_i = 0; bus.irq_i = 0;
    bus.br_immed_i = '0; bus.br_reg_i = '0;
    rst = 0;
  endtask

  task automatic predict();
    #1;
    e_pc_en = !bus.stall_i && !rst;
    e_flush = m_flush && !rst;
    e_ack = 0;
    e_bra = B_INC;
    n_pc = m_pc; n_flush = m_flush; n_ie = m_ie; n_epc = m_epc; n_err = m_err;
    if (rst) begin
      n_pc = '0; n_flush = 0; n_ie = 1; n_epc = '0; n_err = 0;
      m_stk.delete();
    end else if (bus.stall_i) begin
    end else if (m_flush) begin
      n_flush = 0; n_pc = m_pc + ONE;
    end else if (bus.reti_i) begin
      e_bra = B_REG; n_pc = m_epc; n_ie = 1; n_flush = 1;
`ifdef PC_SEQ_CALL_STACK_EN
    end else if (bus.ret_i) begin
      e_bra = B_REG; n_flush = 1;
      if (m_stk.size() > 0) n_pc = m_stk.pop_back();
      else n_err = 1;
`endif
    end else if (bus.call_i) begin
      e_bra = B_IMM; n_pc = bus.br_immed_i; n_flush = 1;
`ifdef PC_SEQ_CALL_STACK_EN
      if (m_stk.size() == DEPTH) begin
        void'(m_stk.pop_front());
        n_err = 1;
      end
      m_stk.push_back(m_pc);
`endif
    end else if (bus.br_req_i) begin
      e_bra = bus.br_sel_i ? B_REG : B_IMM;
      n_pc = bus.br_sel_i ? bus.br_reg_i : bus.br_immed_i;
      n_flush = 1;
    end else if (bus.irq_i && m_ie) begin
      e_bra = B_IRQ; n_pc = '0; n_epc = m_pc; n_ie = 0; e_ack = 1; n_flush = 1;
    end else begin
      n_pc = m_pc + ONE;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    m_pc = n_pc; m_flush = n_flush; m_ie = n_ie; m_epc = n_epc; m_err = n_err;
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      idle_inputs(); rst = 1; bus.br_req_i = 1; bus.irq_i = 1; bus.br_immed_i = 9'h77;
      predict();
      checks++; if (bus.pc_en_o !== 1'b0) begin errors++; $display("FAIL rst_pc_en got %0h want 0", bus.pc_en_o); end
      checks++; if (bus.irq_ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack got %0h want 0", bus.irq_ack_o); end
      advance();
    end
    idle_inputs();
    predict();
    checks++; if (bus.pc_i !== 9'h0) begin errors++; $display("FAIL rst_pc got %0h want 0", bus.pc_i); end
    checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL rst_flush got %0h want 0", bus.flush_o); end
    checks++; if (bus.ie_o !== 1'b1) begin errors++; $display("FAIL rst_ie got %0h want 1", bus.ie_o); end
    checks++; if (bus.epc_o !== 9'h0) begin errors++; $display("FAIL rst_epc got %0h want 0", bus.epc_o); end
    checks++; if (bus.stk_err_o !== 1'b0) begin errors++; $display("FAIL rst_stk_err got %0h want 0", bus.stk_err_o); end
    checks++; if (bus.bra_ctl_o !== B_INC) begin errors++; $display("FAIL rst_bra got %0h want 0", bus.bra_ctl_o); end
    advance();
  endtask

  task automatic test_idle();
    for (int k = 1; k < 5; k++) begin
      idle_inputs();
      predict();
      checks++; if (bus.pc_i !== W'(k)) begin errors++; $display("FAIL idle_pc got %0h want %0h", bus.pc_i, k); end
      checks++; if (bus.bra_ctl_o !== B_INC || bus.flush_o !== 1'b0 || bus.ie_o !== 1'b1)
        begin errors++; $display("FAIL idle_ctl got bra=%0h flush=%0h ie=%0h want 0 0 1", bus.bra_ctl_o, bus.flush_o, bus.ie_o); end
      advance();
    end
  endtask

  task automatic test_branch();
    idle_inputs(); bus.br_req_i = 1; bus.br_immed_i = 9'h40; bus.br_reg_i = 9'h1AB;
    predict();
    checks++; if (bus.pc_i !== 9'h5) begin errors++; $display("FAIL br_start_pc got %0h want 5", bus.pc_i); end
    checks++; if (bus.bra_ctl_o !== B_IMM) begin errors++; $display("FAIL br_bra got %0h want 2", bus.bra_ctl_o); end
    advance();
    idle_inputs(); bus.br_req_i = 1; bus.br_immed_i = 9'h99;
    predict();
    checks++; if (bus.pc_i !== 9'h40) begin errors++; $display("FAIL br_pc got %0h want 40", bus.pc_i); end
    checks++; if (bus.flush_o !== 1'b1 || bus.bra_ctl_o !== B_INC)
      begin errors++; $display("FAIL br_flush got flush=%0h bra=%0h want 1 0", bus.flush_o, bus.bra_ctl_o); end
    advance();
    idle_inputs();
    predict();
    checks++; if (bus.pc_i !== 9'h41 || bus.flush_o !== 1'b0)
      begin errors++; $display("FAIL br_after got pc=%0h flush=%0h want 41 0", bus.pc_i, bus.flush_o); end
    advance();
  endtask

  task automatic test_irq();
    idle_inputs(); bus.irq_i = 1;
    predict();
    checks++; if (bus.pc_i !== 9'h42 || bus.irq_ack_o !== 1'b1 || bus.bra_ctl_o !== B_IRQ)
      begin errors++; $display("FAIL irq_take got pc=%0h ack=%0h bra=%0h want 42 1 1", bus.pc_i, bus.irq_ack_o, bus.bra_ctl_o); end
    advance();
    for (int k = 0; k < 3; k++) begin
      idle_inputs(); bus.irq_i = 1;
      predict();
      checks++; if (bus.pc_i !== W'(k) || bus.irq_ack_o !== 1'b0 || bus.ie_o !== 1'b0 || bus.epc_o !== 9'h42)
        begin errors++; $display("FAIL irq_hold got pc=%0h ack=%0h ie=%0h epc=%0h want %0h 0 0 42", bus.pc_i, bus.irq_ack_o, bus.ie_o, bus.epc_o, k); end
      advance();
    end
    idle_inputs(); bus.reti_i = 1; bus.irq_i = 1;
    predict();
    checks++; if (bus.bra_ctl_o !== B_REG || bus.reg_o !== 9'h42)
      begin errors++; $display("FAIL reti_bra got bra=%0h reg=%0h want 3 42", bus.bra_ctl_o, bus.reg_o); end
    advance();
    idle_inputs(); bus.irq_i = 1;
    predict();
    checks++; if (bus.pc_i !== 9'h42 || bus.ie_o !== 1'b1 || bus.irq_ack_o !== 1'b0)
      begin errors++; $display("FAIL reti_ret got pc=%0h ie=%0h ack=%0h want 42 1 0", bus.pc_i, bus.ie_o, bus.irq_ack_o); end
    advance();
    idle_inputs(); bus.irq_i = 1;
    predict();
    checks++; if (bus.pc_i !== 9'h43 || bus.irq_ack_o !== 1'b1)
      begin errors++; $display("FAIL irq_retake got pc=%0h ack=%0h want 43 1", bus.pc_i, bus.irq_ack_o); end
    advance();
    idle_inputs();
    predict();
    checks++; if (bus.pc_i !== 9'h0 || bus.epc_o !== 9'h43)
      begin errors++; $display("FAIL irq_epc2 got pc=%0h epc=%0h want 0 43", bus.pc_i, bus.epc_o); end
    advance();
    idle_inputs(); bus.reti_i = 1; predict(); advance();
    idle_inputs(); predict(); advance();
  endtask

  task automatic test_irq_vs_branch();
    idle_inputs(); bus.irq_i = 1; bus.br_req_i = 1; bus.br_immed_i = 9'h80;
    predict();
    checks++; if (bus.irq_ack_o !== 1'b0 || bus.bra_ctl_o !== B_IMM)
      begin errors++; $display("FAIL ivb_prio got ack=%0h bra=%0h want 0 2", bus.irq_ack_o, bus.bra_ctl_o); end
    advance();
    idle_inputs(); bus.irq_i = 1;
    predict();
    checks++; if (bus.pc_i !== 9'h80 || bus.irq_ack_o !== 1'b0 || bus.flush_o !== 1'b1)
      begin errors++; $display("FAIL ivb_flush got pc=%0h ack=%0h flush=%0h want 80 0 1", bus.pc_i, bus.irq_ack_o, bus.flush_o); end
    advance();
    idle_inputs(); bus.irq_i = 1;
    predict();
    checks++; if (bus.pc_i !== 9'h81 || bus.irq_ack_o !== 1'b1)
      begin errors++; $display("FAIL ivb_take got pc=%0h ack=%0h want 81 1", bus.pc_i, bus.irq_ack_o); end
    advance();
    idle_inputs();
    predict();
    checks++; if (bus.pc_i !== 9'h0 || bus.epc_o !== 9'h81 || bus.ie_o !== 1'b0)
      begin errors++; $display("FAIL ivb_epc got pc=%0h epc=%0h ie=%0h want 0 81 0", bus.pc_i, bus.epc_o, bus.ie_o); end
    advance();
    idle_inputs(); bus.reti_i = 1; predict(); advance();
    idle_inputs(); predict(); advance();
  endtask

  task automatic test_stall_flush();
    idle_inputs(); bus.br_req_i = 1; bus.br_immed_i = 9'h20; predict(); advance();
    for (int k = 0; k < 3; k++) begin
      idle_inputs(); bus.stall_i = 1; bus.br_req_i = 1; bus.br_immed_i = 9'h155;
      predict();
      checks++; if (bus.pc_i !== 9'h20 || bus.flush_o !== 1'b1 || bus.pc_en_o !== 1'b0)
        begin errors++; $display("FAIL stall_hold got pc=%0h flush=%0h pc_en=%0h want 20 1 0", bus.pc_i, bus.flush_o, bus.pc_en_o); end
      advance();
    end
    idle_inputs();
    predict();
    checks++; if (bus.pc_i !== 9'h20 || bus.flush_o !== 1'b1)
      begin errors++; $display("FAIL stall_end got pc=%0h flush=%0h want 20 1", bus.pc_i, bus.flush_o); end
    advance();
    idle_inputs();
    predict();
    checks++; if (bus.pc_i !== 9'h21 || bus.flush_o !== 1'b0)
      begin errors++; $display("FAIL stall_exit got pc=%0h flush=%0h want 21 0", bus.pc_i, bus.flush_o); end
    advance();
  endtask

  task automatic test_call_stack();
    logic [PCMSB:0] ra [5];
    logic [PCMSB:0] start;
    start = 9'h22;
`ifdef PC_SEQ_CALL_STACK_EN
    for (int i = 0; i < 5; i++) begin
      ra[i] = (i == 0) ? start : W'(9'h100 + 16 * (i - 1) + 1);
      idle_inputs(); bus.call_i = 1; bus.br_immed_i = W'(9'h100 + 16 * i);
      predict();
      checks++; if (bus.pc_i !== ra[i]) begin errors++; $display("FAIL call_pc got %0h want %0h", bus.pc_i, ra[i]); end
      advance();
      idle_inputs(); predict(); advance();
    end
    checks++; if (bus.stk_err_o !== 1'b1) begin errors++; $display("FAIL stk_overflow got %0h want 1", bus.stk_err_o); end
    for (int k = 0; k < 4; k++) begin
      idle_inputs(); bus.ret_i = 1; predict(); advance();
      idle_inputs();
      predict();
      checks++; if (bus.pc_i !== ra[4 - k] || bus.flush_o !== 1'b1)
        begin errors++; $display("FAIL ret_pc got pc=%0h flush=%0h want %0h 1", bus.pc_i, bus.flush_o, ra[4 - k]); end
      advance();
    end
    checks++; if (bus.stk_err_o !== 1'b1) begin errors++; $display("FAIL stk_sticky got %0h want 1", bus.stk_err_o); end
`else
    ra[0] = start;
    idle_inputs(); bus.ret_i = 1;
    predict();
    checks++; if (bus.pc_i !== ra[0] || bus.bra_ctl_o !== B_INC)
      begin errors++; $display("FAIL ret_ignored got pc=%0h bra=%0h want %0h 0", bus.pc_i, bus.bra_ctl_o, ra[0]); end
    advance();
    idle_inputs();
    predict();
    checks++; if (bus.pc_i !== ra[0] + ONE || bus.flush_o !== 1'b0 || bus.stk_err_o !== 1'b0)
      begin errors++; $display("FAIL ret_inc got pc=%0h flush=%0h err=%0h want %0h 0 0", bus.pc_i, bus.flush_o, bus.stk_err_o, ra[0] + ONE); end
    advance();
`endif
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 600; i++) begin
      idle_inputs();
      rst = ($urandom_range(99) == 0);
      bus.stall_i = ($urandom_range(4) == 0);
      bus.irq_i = ($urandom_range(3) == 0);
      bus.br_immed_i = W'($urandom);
      bus.br_reg_i = W'($urandom);
      r = $urandom_range(9);
      case (r)
        0: begin bus.br_req_i = 1; bus.br_sel_i = 1'($urandom); end
        1: bus.call_i = 1;
        2: begin
`ifdef PC_SEQ_CALL_STACK_EN
             bus.ret_i = (m_stk.size() > 0);
`else
             bus.ret_i = 1;
`endif
           end
        3: bus.reti_i = 1;
        default: ;
      endcase
      predict();
      checks++; if (bus.pc_i !== m_pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %0h want %0h", i, bus.pc_i, m_pc); end
      checks++; if (bus.pc_en_o !== e_pc_en) begin errors++; $display("FAIL rnd_pc_en cyc %0d got %0h want %0h", i, bus.pc_en_o, e_pc_en); end
      checks++; if (bus.flush_o !== e_flush) begin errors++; $display("FAIL rnd_flush cyc %0d got %0h want %0h", i, bus.flush_o, e_flush); end
      checks++; if (bus.irq_ack_o !== e_ack) begin errors++; $display("FAIL rnd_ack cyc %0d got %0h want %0h", i, bus.irq_ack_o, e_ack); end
      checks++; if (bus.ie_o !== m_ie) begin errors++; $display("FAIL rnd_ie cyc %0d got %0h want %0h", i, bus.ie_o, m_ie); end
      checks++; if (bus.epc_o !== m_epc) begin errors++; $display("FAIL rnd_epc cyc %0d got %0h want %0h", i, bus.epc_o, m_epc); end
      checks++; if (bus.stk_err_o !== m_err) begin errors++; $display("FAIL rnd_stk_err cyc %0d got %0h want %0h", i, bus.stk_err_o, m_err); end
      if (e_pc_en) begin
        checks++; if (bus.bra_ctl_o !== e_bra) begin errors++; $display("FAIL rnd_bra cyc %0d got %0h want %0h", i, bus.bra_ctl_o, e_bra); end
      end
      advance();
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    m_pc = '0; m_flush = 0; m_ie = 1; m_epc = '0; m_err = 0;
    @(posedge clk); #1;
    test_reset();
    test_idle();
    test_branch();
    test_irq();
    test_irq_vs_branch();
    test_stall_flush();
    test_call_stack();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_seq.md
# pc_seq

Sequencer for the TTA program counter generator (`pc_gen`). It decides each cycle whether the PC advances, branches, vectors to the interrupt handler, or returns from it. It drives `pc_gen`'s `gate_ni`, `bra_ctl_i`, `immed_i` and `reg_i`, and saves the interrupted PC in an exception PC register. It also annuls the one instruction already fetched down a wrong path, handles interrupt enable and acknowledge, and provides an optional hardware call/return stack.

## Interface
- `PCMSB`, 8: MSB of PC and branch targets.
- `DEPTH`, 4: call-stack entries (power of two, 2..16); used only with the call stack.
- `clock_i` in 1: sole clock, rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `stall_i` in 1: fetch/memory not ready; freezes the PC and this block.
- `pc_i` in PCMSB+1: current PC from `pc_gen`.
- `br_req_i` in 1: decoder branch request, single-cycle.
- `br_sel_i` in 1: 0 = immediate target, 1 = register target.
- `br_immed_i` in PCMSB+1: immediate target.
- `br_reg_i` in PCMSB+1: register target.
- `call_i` in 1: call to `br_immed_i`, pushing the return address.
- `ret_i` in 1: return from call (pop).
- `reti_i` in 1: return from interrupt.
- `irq_i` in 1: level interrupt request.
- `pc_en_o` out 1: to `pc_gen.gate_ni`; 1 = PC updates this edge.
- `bra_ctl_o` out 2: to `pc_gen.bra_ctl_i`. 0 = increment, 1 = vector 0, 2 = immediate, 3 = register.
- `immed_o` out PCMSB+1: to `pc_gen.immed_i`.
- `reg_o` out PCMSB+1: to `pc_gen.reg_i`.
- `flush_o` out 1: annul the instruction currently in decode.
- `irq_ack_o` out 1: one-cycle pulse when an interrupt is taken.
- `ie_o` out 1: interrupt enable.
- `epc_o` out PCMSB+1: saved interrupt return PC.
- `stk_err_o` out 1: sticky call-stack overflow/underflow.

## Operation
- FSM states: RUN, FLUSH.
- Reset values:
  - state RUN.
  - `ie_o`=1, `epc_o`=0, `flush_o`=0, `irq_ack_o`=0, `stk_err_o`=0.
  - stack pointer 0.
- `bra_ctl_o`, `immed_o`, `reg_o` and `pc_en_o` are combinational from the state and inputs. `pc_en_o` = !`stall_i` && !`reset_i`.
- In RUN, when not stalled, requests are served by this priority:
  1. `reti_i`: `bra_ctl_o`=3, `reg_o`=`epc_o`, `ie_o`<=1, go to FLUSH.
  2. `ret_i`: `bra_ctl_o`=3, `reg_o`=stack top, pop, go to FLUSH.
  3. `call_i`: `bra_ctl_o`=2, `immed_o`=`br_immed_i`, push `pc_i`, go to FLUSH.
  4. `br_req_i`: `bra_ctl_o`=2+`br_sel_i`, target on `immed_o`/`reg_o`, go to FLUSH.
  5. `irq_i` && `ie_o`: `bra_ctl_o`=1, `epc_o`<=`pc_i`, `ie_o`<=0, `irq_ack_o`=1, go to FLUSH.
  6. Otherwise `bra_ctl_o`=0.
- Lower-priority requests in the same cycle are dropped. The decoder issues at most one request per instruction.
- Interrupts are never taken in FLUSH or in a cycle that has a branch-type request. They are re-evaluated in the next RUN cycle (level-sensitive).
- FLUSH: `flush_o`=1 and `bra_ctl_o`=0. All requests are ignored, because they come from the annulled instruction. Next state is RUN.
- Stall: in either state, with `stall_i`=1, state, `ie_o`, `epc_o`, the stack and all pulses hold. Nothing is pushed, popped or acknowledged. `flush_o` stays asserted while FLUSH is stalled.
- Arithmetic:
  - `epc_o` stores `pc_i` unmodified, i.e. the first unexecuted address.
  - Push stores `pc_i`. The instruction at `pc_i` is annulled, so it is re-executed on return.
  - No PC arithmetic is done here.

## Timing
- Requests are sampled in cycle N. `pc_gen` loads the target at the edge ending cycle N, and the new PC is visible in N+1.
- `flush_o` is high in N+1, one cycle, longer only if stalled.
- `irq_ack_o` is high during cycle N only.
- Minimum spacing between serviced requests is 2 cycles.
- Taken interrupt to first handler fetch at PC 0: one edge.
- Reset mid-FLUSH returns to RUN with `flush_o`=0 in the cycle after reset. `pc_en_o`=0 while `reset_i`=1.

## Configuration
- `PC_SEQ_CALL_STACK_EN` defined:
  - DEPTH-entry LIFO.
  - Push when full overwrites the oldest entry (pointer wraps) and sets `stk_err_o`.
  - Pop when empty returns the stale entry, wraps, and sets `stk_err_o`.
  - `stk_err_o` is cleared only by reset.
- Undefined:
  - `call_i` behaves as `br_req_i` with `br_sel_i`=0 (no push).
  - `ret_i` is ignored (PC increments, no FLUSH).
  - `stk_err_o` is tied 0.
  - No stack storage is instantiated.

## Structure
- Shared package/header:
  - `bra_ctl` encodings: `BRA_INC`=0, `BRA_IRQ`=1, `BRA_IMM`=2, `BRA_REG`=3.
  - State encodings RUN/FLUSH.
  - The interrupt vector constant, 0.
- One sub-module, `pc_stack`: push/pop/top, pointer wrap and error flag. It is only instantiated under the macro.

## Test plan
- Reset, then run 5 cycles idle with `pc_gen` attached → PC 1,2,3,4,5. `bra_ctl_o`=0, `flush_o`=0, `ie_o`=1.
- `br_req_i`, `br_sel_i`=0, `br_immed_i`=0x40 at PC 5 → PC 0x40 next cycle. `flush_o` high for one cycle. A `br_req_i` asserted during FLUSH is ignored.
- `irq_i` held high at PC 0x42 → `irq_ack_o` one pulse, PC 0, `epc_o`=0x42, `ie_o`=0, no re-entry. `reti_i` → PC 0x42, `ie_o`=1, and the interrupt is re-taken two cycles later if `irq_i` is still high.
- `irq_i` and `br_req_i` (target 0x80) in the same cycle → branch taken to 0x80. The interrupt is taken in the first RUN cycle after FLUSH with `epc_o`=0x81.
- `stall_i` high for 3 cycles during FLUSH → PC frozen, `flush_o` high all 3 cycles, exits one cycle after the stall ends.
- With the macro: 5 calls at DEPTH=4 → `stk_err_o`=1. The 4 returns yield the last 4 pushed addresses in reverse order. Without the macro: `ret_i` → PC increments.
